// File: rtl/scaledclock_monitor_pkg.sv
// Shared types and defaults for the scaled-clock monitor.
package scaledclock_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } state_t;

  localparam int          CNT_W_DEF   = 28;
  localparam logic [27:0] TIMEOUT_DEF = 28'd60000000;

endpackage

// File: rtl/scaledclock_monitor_sync_edge_detect.sv
// Synchronizes an async level into clk and flags rise/fall combinationally.
// Edge flags appear SYNC_STAGES edges after the input change; suppressed until the chain is primed after reset.
module sync_edge_detect
  import scaledclock_monitor_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic [SYNC_STAGES:0]   warm;
  logic                   prev;
  logic                   s;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync <= '0;
      warm <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      warm <= {warm[SYNC_STAGES-1:0], 1'b1};
      prev <= s;
    end
  end

  assign s = sync[SYNC_STAGES-1];

  // prev only holds a real sample once the chain has filled; blocks a false edge out of reset
  assign rise = warm[SYNC_STAGES] & s & ~prev;
  assign fall = warm[SYNC_STAGES] & ~s & prev;

endmodule

// File: rtl/scaledclock_monitor.sv
// Fast-domain monitor for a divided clock: registered rise/fall ticks, half-period measurement, loss detect.
// Ticks lag sclk_in by SYNC_STAGES+1 inclk edges; period_valid coincides with the tick.
module scaledclock_monitor
  import scaledclock_monitor_pkg::*;
#(
  parameter int               SYNC_STAGES = 2,
  parameter int               CNT_W       = CNT_W_DEF,
  parameter logic [CNT_W-1:0] TIMEOUT     = CNT_W'(TIMEOUT_DEF)
) (
  input  logic             inclk,
  input  logic             rstn,
  input  logic             ena,
  input  logic             sclk_in,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             rise;
  logic             fall;
  logic             edge_det;
  logic             tick_en;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (inclk),
    .rstn (rstn),
    .din  (sclk_in),
    .rise (rise),
    .fall (fall)
  );

  assign edge_det = rise | fall;
  assign tick_en  = ena & (state != IDLE);

  always_ff @(posedge inclk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      cnt          <= '0;
      half_period  <= '0;
      rise_tick    <= 1'b0;
      fall_tick    <= 1'b0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      rise_tick    <= rise & tick_en;
      fall_tick    <= fall & tick_en;
      period_valid <= 1'b0;

      if (!tick_en || edge_det) begin
        cnt <= '0;
      end else if (cnt != TIMEOUT) begin
        cnt <= cnt + CNT_W'(1);
      end

      // Dropping ena wins over any edge or timeout seen in the same cycle
      if (!ena) begin
        state   <= IDLE;
        locked  <= 1'b0;
        timeout <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= ACQUIRE;
          end
          ACQUIRE: begin
            if (edge_det) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end else if (cnt == TIMEOUT) begin
              state   <= LOST;
              timeout <= 1'b1;
            end
          end
          LOCKED: begin
            if (edge_det) begin
              half_period  <= cnt + CNT_W'(1);
              period_valid <= 1'b1;
            end else if (cnt == TIMEOUT) begin
              state   <= LOST;
              locked  <= 1'b0;
              timeout <= 1'b1;
            end
          end
          LOST: begin
            if (edge_det) begin
              state   <= LOCKED;
              locked  <= 1'b1;
              timeout <= 1'b0;
            end
          end
          default: begin
            state   <= IDLE;
            locked  <= 1'b0;
            timeout <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scaledclock_monitor.sv
// Directed bench for scaledclock_monitor with TIMEOUT=20, CNT_W=8, SYNC_STAGES=2.
module tb_scaledclock_monitor;

  logic       inclk;
  logic       rstn;
  logic       ena;
  logic       sclk_in;
  logic       rise_tick;
  logic       fall_tick;
  logic [7:0] half_period;
  logic       period_valid;
  logic       locked;
  logic       timeout;

  int vectors;
  int miscompares;

  scaledclock_monitor #(
    .SYNC_STAGES (2),
    .CNT_W       (8),
    .TIMEOUT     (8'd20)
  ) dut (
    .inclk        (inclk),
    .rstn         (rstn),
    .ena          (ena),
    .sclk_in      (sclk_in),
    .rise_tick    (rise_tick),
    .fall_tick    (fall_tick),
    .half_period  (half_period),
    .period_valid (period_valid),
    .locked       (locked),
    .timeout      (timeout)
  );

  initial inclk = 1'b0;
  always #5 inclk = ~inclk;

  task automatic cyc();
    @(posedge inclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Toggle sclk_in, then run n cycles; the tick for this toggle lands on the 3rd cycle.
  task automatic blk(input int n, input logic tick_exp, input logic pv_exp,
                     input int hp_exp, input logic lock_exp);
    sclk_in = ~sclk_in;
    for (int c = 1; c <= n; c++) begin
      cyc();
      chk("rise_tick", rise_tick, 32'(tick_exp && c == 3 && sclk_in));
      chk("fall_tick", fall_tick, 32'(tick_exp && c == 3 && !sclk_in));
      chk("period_valid", period_valid, 32'(pv_exp && c == 3));
      if (c == 3) chk("half_period", half_period, hp_exp);
      if (c >= 3) begin
        chk("locked", locked, 32'(lock_exp));
        chk("timeout", timeout, 0);
      end
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rise"}, rise_tick, 0);
    chk({tag, "_fall"}, fall_tick, 0);
    chk({tag, "_pv"}, period_valid, 0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rstn    = 1'b0;
    ena     = 1'b0;
    sclk_in = 1'b0;

    // Reset state
    cyc();
    chk("rst_rise", rise_tick, 0);
    chk("rst_fall", fall_tick, 0);
    chk("rst_pv", period_valid, 0);
    chk("rst_hp", half_period, 0);
    chk("rst_locked", locked, 0);
    chk("rst_timeout", timeout, 0);
    cyc();
    rstn = 1'b1;
    repeat (5) cyc();
    chk("idle_locked", locked, 0);
    ena = 1'b1;
    repeat (2) cyc();
    chk("acq_locked", locked, 0);

    // Toggle every 5 cycles: lock at first tick, first measurement at second edge
    blk(5, 1'b1, 1'b0, 0, 1'b1);
    blk(5, 1'b1, 1'b1, 5, 1'b1);
    blk(5, 1'b1, 1'b1, 5, 1'b1);
    blk(5, 1'b1, 1'b1, 5, 1'b1);

    // ena low for 10 cycles while the source keeps toggling
    ena = 1'b0;
    blk(5, 1'b0, 1'b0, 5, 1'b0);
    blk(5, 1'b0, 1'b0, 5, 1'b0);
    ena = 1'b1;
    blk(5, 1'b1, 1'b0, 5, 1'b1);
    blk(5, 1'b1, 1'b1, 5, 1'b1);

    // Hold sclk_in low: loss declared 21 cycles after the last tick
    repeat (18) cyc();
    chk("pre_to_timeout", timeout, 0);
    chk("pre_to_locked", locked, 1);
    cyc();
    chk("to_timeout", timeout, 1);
    chk("to_locked", locked, 0);
    chk("to_pv", period_valid, 0);
    repeat (4) begin
      cyc();
      chk("lost_timeout", timeout, 1);
      chk_quiet("lost");
    end

    // Recovery without measurement, then period change 5 -> 9
    blk(5, 1'b1, 1'b0, 5, 1'b1);
    blk(5, 1'b1, 1'b1, 5, 1'b1);
    blk(9, 1'b1, 1'b1, 5, 1'b1);
    blk(9, 1'b1, 1'b1, 9, 1'b1);
    blk(9, 1'b1, 1'b1, 9, 1'b1);

    // Async reset between edges while LOCKED, sclk_in left high
    #3;
    rstn = 1'b0;
    #1;
    chk("arst_rise", rise_tick, 0);
    chk("arst_fall", fall_tick, 0);
    chk("arst_pv", period_valid, 0);
    chk("arst_hp", half_period, 0);
    chk("arst_locked", locked, 0);
    chk("arst_timeout", timeout, 0);
    repeat (2) cyc();
    rstn = 1'b1;
    repeat (8) begin
      cyc();
      chk_quiet("post_rst");
      chk("post_rst_locked", locked, 0);
    end

    // Re-enable with sclk_in already high: no rise until a real 0->1
    ena = 1'b0;
    repeat (3) cyc();
    ena = 1'b1;
    repeat (6) begin
      cyc();
      chk_quiet("ena_high");
      chk("ena_high_locked", locked, 0);
    end
    blk(5, 1'b1, 1'b0, 0, 1'b1);
    blk(5, 1'b1, 1'b1, 5, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/scaledclock_monitor.md
Name: scaledclock_monitor

Overview:
- Fast-domain receiver for the divided clock that the bus clock divider produces. Sits at any bus block that consumes the scaled clock.
- Synchronizes the slow clock into the `inclk` domain and emits single-cycle rise/fall ticks.
- Measures the half-period in `inclk` cycles and flags loss of the scaled clock.
- Bus logic runs on `inclk` gated by these ticks, so it does not clock flops directly from the divided signal.

Parameters:
- SYNC_STAGES, 2: synchronizer flop count; legal range ≥2.
- CNT_W, 28: width of the interval counter and of `half_period`.
- TIMEOUT, 28'd60000000: `inclk` cycles without a detected edge before loss is declared. Must exceed the divider maxcount+1.

Ports:
- inclk  in  1  fast system clock; all logic on its rising edge.
- rstn  in  1  asynchronous active-low reset.
- ena  in  1  monitor enable; low forces IDLE.
- sclk_in  in  1  divided clock, asynchronous to inclk.
- rise_tick  out  1  one-cycle pulse per detected rising edge.
- fall_tick  out  1  one-cycle pulse per detected falling edge.
- half_period  out  CNT_W  last measured edge-to-edge interval in `inclk` cycles.
- period_valid  out  1  one-cycle pulse when `half_period` updates.
- locked  out  1  high in LOCKED state.
- timeout  out  1  high in LOST state.

Behaviour:
- Reset (`rstn`=0, async):
  - sync chain, `prev`, `cnt`, `half_period` = 0.
  - state = IDLE.
  - all outputs = 0.
- Sync and edge detect:
  - `sclk_in` passes through SYNC_STAGES flops to give `s`; `prev` <= `s` each cycle.
  - rise = `s` & ~`prev`; fall = ~`s` & `prev`.
  - Ticks are registered. A `sclk_in` change meeting setup before edge k gives a tick high during the cycle after edge k+SYNC_STAGES. Latency is SYNC_STAGES+1 edges (3 by default).
  - Ticks assert only in ACQUIRE, LOCKED and LOST. In IDLE they are 0, but the sync chain and `prev` keep running so there is no false edge on enable.
- Counter `cnt`:
  - In IDLE it is held at 0.
  - Otherwise, on a detected edge it loads 0, else it increments.
  - It saturates at TIMEOUT and does not wrap.
- States:
  - IDLE: if `ena`=1, go to ACQUIRE.
  - ACQUIRE: an edge goes to LOCKED with no measurement, since the first interval is partial. `cnt`==TIMEOUT goes to LOST.
  - LOCKED: on an edge, `half_period` <= `cnt`+1 and `period_valid` pulses in the same cycle as the tick; stay LOCKED. `cnt`==TIMEOUT goes to LOST.
  - LOST: `timeout`=1. An edge goes to LOCKED, clears `timeout`, and takes no measurement.
  - Any state: `ena`=0 goes to IDLE next cycle. This overrides a simultaneous edge or timeout.
- `half_period` holds its value across IDLE and LOST; only reset clears it.
- Measurement rule: a source toggling every N+1 `inclk` cycles (divider maxcount=N) yields `half_period`=N+1.
- Edge and timeout in the same cycle: the edge wins; state stays or goes to LOCKED.
- Glitch: a pulse shorter than one `inclk` period may be missed; no requirement to catch it.
- Reset mid-operation: immediate return to reset values; no tick or `period_valid` is emitted after reset deasserts until a new edge.

Decomposition:
- Shared package:
  - state enum {IDLE, ACQUIRE, LOCKED, LOST}, 2 bits.
  - CNT_W default.
  - TIMEOUT default.
- One sub-module: `sync_edge_detect`, holding the SYNC_STAGES flops, `prev`, and the rise/fall outputs. It is reusable for other async inputs (buttons, ena).
- The FSM and counter stay in `scaledclock_monitor`.

Test Plan (bench settings: TIMEOUT=20, CNT_W=8, SYNC_STAGES=2):
- Reset, then `ena`=1, then `sclk_in` toggling every 5 `inclk` cycles:
  - `locked`=1 three cycles after the first toggle.
  - the first `period_valid` comes at the 2nd edge with `half_period`=5.
  - `rise_tick`/`fall_tick` alternate, each exactly 1 cycle wide.
- `sclk_in` held at 0 for 25 cycles while LOCKED:
  - `timeout`=1 when `cnt` reaches 20, 21 cycles after the last tick, and `locked`=0.
  - the next toggle gives `locked`=1, `timeout`=0, and no `period_valid`.
- Period change from 5 to 9 cycles while LOCKED: `half_period` 5 then 9, updating at the first edge after the change.
- Drop `ena` mid-stream for 10 cycles:
  - no ticks; state IDLE.
  - `half_period` holds 5.
  - on re-enable, state passes through ACQUIRE, and the first measurement comes only at the second edge.
- Assert `rstn`=0 asynchronously between clock edges while LOCKED:
  - all outputs 0 immediately.
  - `half_period`=0.
  - no spurious tick after release with `sclk_in`=1 steady.
- `sclk_in` at 1 when `ena` rises: no `rise_tick` until a genuine 0→1 transition.
